// File: rtl/handle_shift_multi_pkg.sv
// Shared codes for the shift handler: direction codes, FSM states, message defaults.
package handle_shift_multi_pkg;

  localparam logic [1:0] SHIFT_DIR_L = 2'd0;
  localparam logic [1:0] SHIFT_DIR_R = 2'd1;
  localparam logic [1:0] SHIFT_DIR_U = 2'd2;
  localparam logic [1:0] SHIFT_DIR_D = 2'd3;

  localparam logic [2:0] MSG_SHIFT_DFLT   = 3'd4;
  localparam logic [3:0] SHIFT_STATE_DFLT = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACTIVE   = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DONE     = 3'd4
  } shift_state_e;

  // Encode a one-hot {down, up, right, left} request vector into a direction code.
  function automatic logic [1:0] dir_code(input logic [3:0] moves);
    logic [1:0] code;
    code = SHIFT_DIR_L;
    if (moves[1])      code = SHIFT_DIR_R;
    else if (moves[2]) code = SHIFT_DIR_U;
    else if (moves[3]) code = SHIFT_DIR_D;
    return code;
  endfunction

endpackage

// File: rtl/handle_shift_multi_shift_req_fifo.sv
// Small request FIFO holding 2-bit direction codes; async reset plus sync clear.
module handle_shift_multi_shift_req_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];

  // Pointer/count update; clear wins over push and pop, full drops the push.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/handle_shift_multi.sv
// Multi-step shift handler: queues move requests, bounds-checks them against the
// card-group cursor and issues one shift message per legal move.
// Optional horizontal wrap-around is compiled in with SHIFT_WRAP_EN.
module handle_shift_multi
  import handle_shift_multi_pkg::*;
#(
  parameter int unsigned PLAYER      = 0,
  parameter int unsigned COLS        = 18,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned X_W         = 5,
  parameter int unsigned Y_W         = 3,
  parameter int unsigned DEPTH       = 4,
  parameter logic [3:0]  SHIFT_STATE = SHIFT_STATE_DFLT,
  parameter logic [2:0]  MSG_SHIFT   = MSG_SHIFT_DFLT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           interboard_rst,
  input  logic           shift_en,
  input  logic [3:0]     cur_game_state,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           move_up,
  input  logic           move_down,
  input  logic [X_W-1:0] start_x,
  input  logic [Y_W-1:0] start_y,
  input  logic [2:0]     start_len,
  input  logic [5:0]     start_card,
  input  logic           inter_ready,
  output logic           shift_done,
  output logic           shift_ctrl_en,
  output logic [1:0]     shift_ctrl_move_dir,
  output logic [X_W-1:0] shift_ctrl_block_x,
  output logic [Y_W-1:0] shift_ctrl_block_y,
  output logic [3:0]     shift_ctrl_msg_type,
  output logic [5:0]     shift_ctrl_card,
  output logic [2:0]     shift_ctrl_sel_len,
  output logic           shift_overflow
);

`ifdef SHIFT_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [3:0] MSG_TYPE = {1'(PLAYER % 2), MSG_SHIFT};

  shift_state_e   state_q, state_d;
  logic [X_W-1:0] x_q, x_d, bx_q, bx_d;
  logic [Y_W-1:0] y_q, y_d, by_q, by_d;
  logic [2:0]     len_q, len_d;
  logic [5:0]     card_q, card_d;
  logic [1:0]     dir_q, dir_d;
  logic [3:0]     msg_q, msg_d;
  logic           ovf_q, ovf_d, abort_q, abort_d, en_q, en_d, done_q, done_d;

  logic [3:0]     moves;
  logic           in_phase, enq_ok, req_one, push_c, pop_c, clr_c, flush_c;
  logic [1:0]     head;
  logic           fifo_full, fifo_empty;
  logic [X_W:0]   x_end;
  logic           at_left, at_right, at_top, at_bot, head_legal;

  assign moves    = {move_down, move_up, move_right, move_left};
  assign in_phase = (cur_game_state == SHIFT_STATE);
  assign enq_ok   = (state_q == ST_ACTIVE) || (state_q == ST_ISSUE) || (state_q == ST_WAIT_RDY);
  assign req_one  = $onehot(moves);
  assign push_c   = enq_ok && req_one;
  assign clr_c    = interboard_rst || flush_c;

  // Boundary flags for the current cursor; x+len is one bit wider so it never wraps.
  assign x_end    = {1'b0, x_q} + (X_W+1)'(len_q);
  assign at_left  = (x_q == '0);
  assign at_right = (x_end >= (X_W+1)'(COLS));
  assign at_top   = (y_q == '0);
  assign at_bot   = (y_q == Y_W'(ROWS - 1));

  // Legality of the FIFO head against the cursor.
  always_comb begin
    head_legal = 1'b0;
    unique case (head)
      SHIFT_DIR_L: head_legal = WRAP_EN || !at_left;
      SHIFT_DIR_R: head_legal = WRAP_EN || !at_right;
      SHIFT_DIR_U: head_legal = !at_top;
      default:     head_legal = !at_bot;
    endcase
  end

  handle_shift_multi_shift_req_fifo #(.DEPTH(DEPTH)) u_shift_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_c),
    .push  (push_c),
    .pop   (pop_c),
    .din   (dir_code(moves)),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, cursor and message register logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    len_d   = len_q;
    card_d  = card_q;
    ovf_d   = ovf_q;
    abort_d = abort_q;
    dir_d   = dir_q;
    bx_d    = bx_q;
    by_d    = by_q;
    msg_d   = msg_q;
    en_d    = 1'b0;
    pop_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (shift_en && in_phase) begin
          state_d = ST_ACTIVE;
          x_d     = start_x;
          y_d     = start_y;
          len_d   = start_len;
          card_d  = start_card;
          ovf_d   = 1'b0;
          abort_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (!in_phase) begin
          state_d = ST_DONE;
        end else if (!fifo_empty) begin
          pop_c = 1'b1;
          if (head_legal) begin
            state_d = ST_ISSUE;
            en_d    = 1'b1;
            dir_d   = head;
            bx_d    = x_q;
            by_d    = y_q;
            msg_d   = MSG_TYPE;
          end
        end else if (!shift_en) begin
          state_d = ST_DONE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_RDY;
        unique case (dir_q)
          SHIFT_DIR_L: x_d = at_left ? (X_W'(COLS) - X_W'(len_q)) : (x_q - X_W'(1));
          SHIFT_DIR_R: x_d = at_right ? '0 : (x_q + X_W'(1));
          SHIFT_DIR_U: y_d = y_q - Y_W'(1);
          default:     y_d = y_q + Y_W'(1);
        endcase
      end
      ST_WAIT_RDY: begin
        if (inter_ready) begin
          if (abort_q || !in_phase)        state_d = ST_DONE;
          else if (!shift_en && fifo_empty) state_d = ST_DONE;
          else                              state_d = ST_ACTIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving the game state mid-transfer is remembered until the transfer finishes.
    if (((state_q == ST_ISSUE) || (state_q == ST_WAIT_RDY)) && !in_phase) abort_d = 1'b1;
    if (push_c && fifo_full) ovf_d = 1'b1;

    flush_c = (state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);

    if (interboard_rst) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
      len_d   = '0;
      card_d  = '0;
      ovf_d   = 1'b0;
      abort_d = 1'b0;
      dir_d   = '0;
      bx_d    = '0;
      by_d    = '0;
      msg_d   = '0;
      en_d    = 1'b0;
      done_d  = 1'b0;
      pop_c   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      len_q   <= '0;
      card_q  <= '0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
      dir_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      msg_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      len_q   <= len_d;
      card_q  <= card_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
      dir_q   <= dir_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      msg_q   <= msg_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign shift_done          = done_q;
  assign shift_ctrl_en       = en_q;
  assign shift_ctrl_move_dir = dir_q;
  assign shift_ctrl_block_x  = bx_q;
  assign shift_ctrl_block_y  = by_q;
  assign shift_ctrl_msg_type = msg_q;
  assign shift_ctrl_card     = card_q;
  assign shift_ctrl_sel_len  = len_q;
  assign shift_overflow      = ovf_q;

endmodule

// File: tb/tb_handle_shift_multi.sv
// Directed bench for handle_shift_multi (default parameters).
module tb_handle_shift_multi;

  localparam int unsigned X_W = 5;
  localparam int unsigned Y_W = 3;
`ifdef SHIFT_WRAP_EN
  localparam int WRAP = 1;
`else
  localparam int WRAP = 0;
`endif
  localparam logic [3:0] MV_L = 4'b0001;
  localparam logic [3:0] MV_R = 4'b0010;
  localparam logic [3:0] MV_U = 4'b0100;
  localparam logic [3:0] MV_D = 4'b1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           interboard_rst = 1'b0;
  logic           shift_en = 1'b0;
  logic [3:0]     cur_game_state = 4'd0;
  logic           move_left = 1'b0, move_right = 1'b0, move_up = 1'b0, move_down = 1'b0;
  logic [X_W-1:0] start_x = '0;
  logic [Y_W-1:0] start_y = '0;
  logic [2:0]     start_len = '0;
  logic [5:0]     start_card = '0;
  logic           inter_ready = 1'b0;
  logic           shift_done, shift_ctrl_en, shift_overflow;
  logic [1:0]     shift_ctrl_move_dir;
  logic [X_W-1:0] shift_ctrl_block_x;
  logic [Y_W-1:0] shift_ctrl_block_y;
  logic [3:0]     shift_ctrl_msg_type;
  logic [5:0]     shift_ctrl_card;
  logic [2:0]     shift_ctrl_sel_len;

  handle_shift_multi dut (
    .clk                 (clk),
    .rst                 (rst),
    .interboard_rst      (interboard_rst),
    .shift_en            (shift_en),
    .cur_game_state      (cur_game_state),
    .move_left           (move_left),
    .move_right          (move_right),
    .move_up             (move_up),
    .move_down           (move_down),
    .start_x             (start_x),
    .start_y             (start_y),
    .start_len           (start_len),
    .start_card          (start_card),
    .inter_ready         (inter_ready),
    .shift_done          (shift_done),
    .shift_ctrl_en       (shift_ctrl_en),
    .shift_ctrl_move_dir (shift_ctrl_move_dir),
    .shift_ctrl_block_x  (shift_ctrl_block_x),
    .shift_ctrl_block_y  (shift_ctrl_block_y),
    .shift_ctrl_msg_type (shift_ctrl_msg_type),
    .shift_ctrl_card     (shift_ctrl_card),
    .shift_ctrl_sel_len  (shift_ctrl_sel_len),
    .shift_overflow      (shift_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  logic [X_W-1:0] xq[$];

  // Background log of message pulses and completion pulses.
  always @(negedge clk) begin
    if (shift_ctrl_en === 1'b1) begin
      en_cnt++;
      xq.push_back(shift_ctrl_block_x);
    end
    if (shift_done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({shift_done, shift_ctrl_en, shift_ctrl_move_dir, shift_ctrl_block_x,
                shift_ctrl_block_y, shift_ctrl_msg_type, shift_ctrl_card,
                shift_ctrl_sel_len, shift_overflow});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [3:0] m);
    {move_down, move_up, move_right, move_left} = m;
    tick();
    {move_down, move_up, move_right, move_left} = 4'b0000;
  endtask

  task automatic ready_pulse();
    inter_ready = 1'b1;
    tick();
    inter_ready = 1'b0;
  endtask

  task automatic enter(input int x, input int y, input int len, input int card);
    start_x        = X_W'(x);
    start_y        = Y_W'(y);
    start_len      = 3'(len);
    start_card     = 6'(card);
    shift_en       = 1'b1;
    cur_game_state = 4'd5;
    tick();
  endtask

  task automatic wait_msg(input string tag);
    int k;
    k = 0;
    while (shift_ctrl_en !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(shift_ctrl_en), 32'd1);
  endtask

  initial begin
    int e0, e1, d0;

    // Reset state
    quiet(2);
    check_eq("rst_outs", outs(), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_outs", outs(), 32'd0);

    // Basic move with exact latency and full message contents
    enter(3, 2, 3, 'h11);
    pulse(MV_R);
    check_eq("lat_no_en_yet", 32'(shift_ctrl_en), 32'd0);
    tick();
    check_eq("r_en", 32'(shift_ctrl_en), 32'd1);
    check_eq("r_dir", 32'(shift_ctrl_move_dir), 32'd1);
    check_eq("r_x", 32'(shift_ctrl_block_x), 32'd3);
    check_eq("r_y", 32'(shift_ctrl_block_y), 32'd2);
    check_eq("r_msg", 32'(shift_ctrl_msg_type), 32'h4);
    check_eq("r_card", 32'(shift_ctrl_card), 32'h11);
    check_eq("r_len", 32'(shift_ctrl_sel_len), 32'd3);
    tick();
    check_eq("r_en_pulse", 32'(shift_ctrl_en), 32'd0);
    check_eq("r_x_hold", 32'(shift_ctrl_block_x), 32'd3);
    quiet(2);
    ready_pulse();
    pulse(MV_U);
    tick();
    check_eq("u_en", 32'(shift_ctrl_en), 32'd1);
    check_eq("u_dir", 32'(shift_ctrl_move_dir), 32'd2);
    check_eq("u_x", 32'(shift_ctrl_block_x), 32'd4);
    check_eq("u_y", 32'(shift_ctrl_block_y), 32'd2);
    tick();
    ready_pulse();

    // Two moves in one cycle are ignored; cursor unchanged
    e0 = en_cnt;
    pulse(MV_L | MV_U);
    quiet(4);
    check_eq("dual_none", 32'(en_cnt - e0), 32'd0);
    pulse(MV_D);
    wait_msg("d_seen");
    check_eq("d_dir", 32'(shift_ctrl_move_dir), 32'd3);
    check_eq("d_x", 32'(shift_ctrl_block_x), 32'd4);
    check_eq("d_y", 32'(shift_ctrl_block_y), 32'd1);
    tick();
    ready_pulse();
    shift_en = 1'b0;
    tick();
    check_eq("done_pulse", 32'(shift_done), 32'd1);
    tick();
    check_eq("done_one_cycle", 32'(shift_done), 32'd0);

    // Left edge: dropped, or wrapped with pre-move x=0
    enter(0, 0, 3, 'h2A);
    e0 = en_cnt;
    xq.delete();
    pulse(MV_L);
    quiet(4);
    check_eq("left_edge_cnt", 32'(en_cnt - e0), 32'(WRAP));
    ready_pulse();
    pulse(MV_D);
    wait_msg("left_next_seen");
    check_eq("left_next_x", 32'(shift_ctrl_block_x), (WRAP != 0) ? 32'd15 : 32'd0);
    check_eq("left_next_y", 32'(shift_ctrl_block_y), 32'd0);
    tick();
    ready_pulse();
    shift_en = 1'b0;
    quiet(2);

    // Right edge (x+len==COLS) and bottom edge
    enter(15, 7, 3, 'h01);
    e0 = en_cnt;
    pulse(MV_R);
    quiet(4);
    check_eq("right_edge_cnt", 32'(en_cnt - e0), 32'(WRAP));
    ready_pulse();
    e1 = en_cnt;
    pulse(MV_D);
    quiet(4);
    check_eq("bottom_edge_cnt", 32'(en_cnt - e1), 32'd0);
    pulse(MV_U);
    wait_msg("up_from_bottom_seen");
    check_eq("up_from_bottom_y", 32'(shift_ctrl_block_y), 32'd7);
    check_eq("up_from_bottom_x", 32'(shift_ctrl_block_x), (WRAP != 0) ? 32'd0 : 32'd15);
    tick();
    ready_pulse();
    shift_en = 1'b0;
    quiet(2);

    // Overflow: six requests while waiting, four kept
    enter(0, 3, 3, 'h05);
    pulse(MV_R);
    wait_msg("ovf_first_seen");
    tick();
    move_right = 1'b1;
    quiet(6);
    move_right = 1'b0;
    check_eq("ovf_set", 32'(shift_overflow), 32'd1);
    xq.delete();
    e0 = en_cnt;
    inter_ready = 1'b1;
    quiet(20);
    inter_ready = 1'b0;
    check_eq("ovf_msg_cnt", 32'(en_cnt - e0), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("ovf_x_seq", 32'(xq[i]), 32'(i + 1));
    check_eq("ovf_sticky", 32'(shift_overflow), 32'd1);
    shift_en = 1'b0;
    quiet(2);

    // shift_en drops with two queued: both complete, then done
    enter(0, 3, 3, 'h05);
    check_eq("ovf_clr_on_entry", 32'(shift_overflow), 32'd0);
    e0 = en_cnt;
    d0 = done_cnt;
    pulse(MV_R);
    wait_msg("drain_m1");
    tick();
    pulse(MV_R);
    pulse(MV_R);
    shift_en = 1'b0;
    ready_pulse();
    check_eq("drain_no_done1", 32'(shift_done), 32'd0);
    wait_msg("drain_m2");
    tick();
    ready_pulse();
    check_eq("drain_no_done2", 32'(shift_done), 32'd0);
    wait_msg("drain_m3");
    tick();
    ready_pulse();
    check_eq("drain_done", 32'(shift_done), 32'd1);
    tick();
    check_eq("drain_done_off", 32'(shift_done), 32'd0);
    check_eq("drain_msgs", 32'(en_cnt - e0), 32'd3);
    check_eq("drain_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Game state leaves during WAIT_RDY: finish, flush, done
    enter(0, 3, 3, 'h05);
    e0 = en_cnt;
    d0 = done_cnt;
    pulse(MV_R);
    wait_msg("leave_m1");
    tick();
    pulse(MV_R);
    pulse(MV_R);
    cur_game_state = 4'd6;
    quiet(3);
    check_eq("leave_wait_held", 32'(shift_done), 32'd0);
    ready_pulse();
    check_eq("leave_done", 32'(shift_done), 32'd1);
    shift_en = 1'b0;
    quiet(4);
    cur_game_state = 4'd5;
    check_eq("leave_flushed", 32'(en_cnt - e0), 32'd1);
    check_eq("leave_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Async reset in WAIT_RDY
    enter(2, 2, 3, 'h3F);
    pulse(MV_R);
    wait_msg("arst_m");
    tick();
    check_eq("arst_busy", 32'(outs() != 32'd0), 32'd1);
    shift_en = 1'b0;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_eq("arst_outs", outs(), 32'd0);
    tick();
    rst = 1'b0;
    ready_pulse();
    quiet(3);
    check_eq("arst_no_done", 32'(done_cnt - d0), 32'd0);

    // Sync interboard reset in WAIT_RDY
    enter(2, 2, 3, 'h3F);
    pulse(MV_R);
    wait_msg("srst_m");
    tick();
    shift_en = 1'b0;
    d0 = done_cnt;
    interboard_rst = 1'b1;
    #1;
    check_eq("srst_before_edge", 32'(outs() != 32'd0), 32'd1);
    tick();
    check_eq("srst_outs", outs(), 32'd0);
    interboard_rst = 1'b0;
    ready_pulse();
    quiet(3);
    check_eq("srst_no_done", 32'(done_cnt - d0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
